// File: rtl/shift_word_serializer.sv
// Serializer feeding a bidirectional shift register from a valid/ready word stream.
// Three-state FSM: IDLE, SHIFT (one bit per cycle) and DONE (word_valid pulse).
module shift_word_serializer #(
  parameter int   WIDTH     = 4,
  parameter logic IDLE_FILL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_shiftR,
  output logic             word_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    count;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic             accept;

  assign in_ready = ~reset & (state == IDLE | state == DONE);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      data_q <= '0;
      dir_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        data_q <= in_data;
        dir_q  <= in_dir;
        count  <= '0;
      end else if (state == SHIFT && count != LAST) begin
        count <= count + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = SHIFT;
      SHIFT:   if (count == LAST) state_nx = DONE;
      DONE:    state_nx = accept ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Right shift enters at the MSB, so it must see the LSB first.
  assign idx = dir_q ? count : LAST - count;

  always_comb begin
    ser_bit    = IDLE_FILL;
    ser_shiftR = 1'b0;
    word_valid = 1'b0;
    busy       = 1'b0;
    unique case (state)
      SHIFT: begin
        ser_bit    = data_q[idx];
        ser_shiftR = dir_q;
        busy       = 1'b1;
      end
      DONE: begin
        ser_shiftR = dir_q;
        word_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_word_serializer.sv
// Directed and random bench for shift_word_serializer.
// A 4-bit shift register model stands in for the downstream consumer.
module tb_shift_word_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_dir;
  logic       in_ready;
  logic       ser_bit;
  logic       ser_shiftR;
  logic       word_valid;
  logic       busy;
  logic [3:0] dreg;

  int checks   = 0;
  int failures = 0;

  shift_word_serializer #(.WIDTH(4), .IDLE_FILL(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_dir     (in_dir),
    .in_ready   (in_ready),
    .ser_bit    (ser_bit),
    .ser_shiftR (ser_shiftR),
    .word_valid (word_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Downstream register: shifts every cycle, no hold, load tied low.
  always @(posedge clk)
    dreg <= ser_shiftR ? {ser_bit, dreg[3:1]} : {dreg[2:0], ser_bit};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic dir);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // seq lists the expected serial bits left to right in cycle order.
  task automatic shift_check(input string tag, input logic [3:0] word,
                             input logic dir, input logic [0:3] seq);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_bit"}, 32'(ser_bit), 32'(seq[k]));
      chk({tag, "_dir"}, 32'(ser_shiftR), 32'(dir));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
      step();
    end
    chk({tag, "_wv"}, 32'(word_valid), 32'd1);
    chk({tag, "_dout"}, 32'(dreg), 32'(word));
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0] q[$];
    logic [3:0] exp_w;
    int acc;
    int pulses;
    bit took;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 4'h0;
    in_dir   = 1'b0;

    // Reset state
    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    repeat (2) step();
    chk("rst_bit", 32'(ser_bit), 32'd0);
    chk("rst_shr", 32'(ser_shiftR), 32'd0);
    chk("rst_wv", 32'(word_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready2", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", 32'(in_ready), 32'd1);

    // Reset held two cycles mid-SHIFT aborts the word
    send(4'b1010, 1'b1);
    chk("mid_shr", 32'(ser_shiftR), 32'd1);
    step();
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    step();
    step();
    chk("mid_rst_bit", 32'(ser_bit), 32'd0);
    chk("mid_rst_shr", 32'(ser_shiftR), 32'd0);
    chk("mid_rst_wv", 32'(word_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_rel_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_no_wv", 32'(word_valid), 32'd0);
    end

    // 1011 via right shift: LSB first
    send(4'b1011, 1'b1);
    shift_check("r1011", 4'b1011, 1'b1, 4'b1101);
    step();
    chk("r1011_after_shr", 32'(ser_shiftR), 32'd0);

    // 1011 via left shift: MSB first
    send(4'b1011, 1'b0);
    shift_check("l1011", 4'b1011, 1'b0, 4'b1011);
    step();

    // Back-to-back: second word accepted in the DONE cycle
    in_valid = 1'b1;
    in_data  = 4'h6;
    in_dir   = 1'b1;
    chk("b2b_ready0", 32'(in_ready), 32'd1);
    step();
    in_data = 4'h9;
    in_dir  = 1'b0;
    shift_check("b2b_6", 4'h6, 1'b1, 4'b0110);
    chk("b2b_done_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    shift_check("b2b_9", 4'h9, 1'b0, 4'b1001);
    step();

    // Inputs changing during SHIFT are ignored
    send(4'b1100, 1'b0);
    in_valid = 1'b1;
    in_data  = 4'b0011;
    in_dir   = 1'b1;
    shift_check("hold", 4'b1100, 1'b0, 4'b1100);
    in_valid = 1'b0;
    step();
    chk("hold_idle_ready", 32'(in_ready), 32'd1);
    chk("hold_idle_shr", 32'(ser_shiftR), 32'd0);
    chk("hold_idle_wv", 32'(word_valid), 32'd0);

    // Random words, directions and gaps
    acc    = 0;
    pulses = 0;
    took   = 1'b0;
    for (int cyc = 0; cyc < 20000 && (acc < 1000 || q.size() > 0); cyc++) begin
      if (word_valid) begin
        pulses++;
        chk("rand_pending", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          exp_w = q.pop_front();
          chk("rand_dout", 32'(dreg), 32'(exp_w));
        end
      end
      if (took) in_valid = 1'b0;
      took = 1'b0;
      if (!in_valid && acc < 1000 && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_data  = 4'($urandom_range(0, 15));
        in_dir   = 1'($urandom_range(0, 1));
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        acc++;
        took = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    chk("rand_accepts", 32'(acc), 32'd1000);
    chk("rand_pulses", 32'(pulses), 32'(acc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
